// File: rtl/result_sign_decoder_pkg.sv
// Shared definitions for the sign-magnitude decoder: FSM encoding and default width.
package result_sign_decoder_pkg;

    localparam int DATA_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/result_sign_decoder_if.sv
// Input and output valid/ready streams of the decoder, bundled as one interface.
interface result_sign_decoder_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_cout;
  logic         out_valid;
  logic         out_ready;
  logic         out_sign;
  logic [N-1:0] out_mag;
  logic         out_err;

  // Decoder side.
  modport slave (
    input  in_valid, in_data, in_cout, out_ready,
    output in_ready, out_valid, out_sign, out_mag, out_err
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, in_cout, out_ready,
    input  in_ready, out_valid, out_sign, out_mag, out_err
  );
endinterface

// File: rtl/result_sign_decoder_serial_negate_cell.sv
// One bit of a serial two's-complement negator: copy bits up to the first 1, invert after it.
module serial_negate_cell (
  input  logic b,
  input  logic neg,
  input  logic seen_one,
  output logic o,
  output logic seen_one_next
);
  assign o             = neg ? (b ^ seen_one) : b;
  assign seen_one_next = seen_one | b;
endmodule

// File: rtl/result_sign_decoder.sv
// Converts subtractor result/carry into sign-magnitude, one bit per clock, LSB first.
module result_sign_decoder
  import result_sign_decoder_pkg::*;
#(
  parameter int N = DATA_W_DEFAULT
) (
  input logic                  clk,
  input logic                  rst,
  result_sign_decoder_if.slave bus
);
  localparam int             CNT_W    = (N > 2) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  state_t           state_reg;
  logic [N-1:0]     shift_reg;
  logic [N-1:0]     acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             seen_one_reg;
  logic             neg_reg;
  logic             sign_reg;
  logic             err_reg;
  logic             out_valid_reg;
  logic             in_ready_reg;

  logic             cell_o;
  logic             seen_one_next;

  serial_negate_cell u_cell (
    .b             (shift_reg[0]),
    .neg           (neg_reg),
    .seen_one      (seen_one_reg),
    .o             (cell_o),
    .seen_one_next (seen_one_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      shift_reg     <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      seen_one_reg  <= 1'b0;
      neg_reg       <= 1'b0;
      sign_reg      <= 1'b0;
      err_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            shift_reg    <= bus.in_data;
            neg_reg      <= ~bus.in_cout;
            sign_reg     <= ~bus.in_cout;
            // A borrow with a zero result would need magnitude 2^N.
            err_reg      <= ~bus.in_cout & (bus.in_data == '0);
            cnt_reg      <= '0;
            seen_one_reg <= 1'b0;
            acc_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Bits enter at the MSB so the first (LSB) bit ends at acc_reg[0] after N shifts.
          shift_reg    <= {1'b0, shift_reg[N-1:1]};
          acc_reg      <= {cell_o, acc_reg[N-1:1]};
          seen_one_reg <= seen_one_next;
          cnt_reg      <= cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_CNT) begin
            out_valid_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sign  = sign_reg;
  assign bus.out_mag   = acc_reg;
  assign bus.out_err   = err_reg;
endmodule
